arith_unit: RTL and testbench

Parametrised, command-driven arithmetic unit: the next generation of the switch/button adder used on the DE2-115 boards. It takes two WIDTH-bit operands, executes one of five operations on a rising edge of a synchronised start level, and holds a 2·WIDTH-bit result for the seven-segment and LED drivers. Multiply runs as a multi-cycle shift-add sequence, so the block exposes busy/done status. It sits between the `button` synchronisers and the `sevseg` decoders in board top levels.

---
 rtl/arith_unit_pkg.sv | 15 +
 rtl/arith_unit_if.sv | 17 +
 rtl/arith_unit_shift_add_mul.sv | 46 ++++
 rtl/arith_unit.sv | 97 +++++++++
 tb/tb_arith_unit.sv | 208 ++++++++++++++++++++
 5 files changed

// File: rtl/arith_unit_pkg.sv
// arith_unit_pkg: op codes and FSM encodings shared by arith_unit, board tops and benches.
package arith_unit_pkg;

    localparam logic [2:0] OP_CLR = 3'd0;
    localparam logic [2:0] OP_ADD = 3'd1;
    localparam logic [2:0] OP_SUB = 3'd2;
    localparam logic [2:0] OP_MUL = 3'd3;
    localparam logic [2:0] OP_ACC = 3'd4;

    typedef enum logic [0:0] {
        S_IDLE = 1'b0,
        S_MUL  = 1'b1
    } state_t;

endpackage

// File: rtl/arith_unit_if.sv
// arith_unit_if: command/result bundle between a command source and arith_unit.
interface arith_unit_if #(parameter int WIDTH = 8);

    logic                 start;
    logic [2:0]           op;
    logic [WIDTH-1:0]     a;
    logic [WIDTH-1:0]     b;
    logic [2*WIDTH-1:0]   result;
    logic                 busy;
    logic                 done;
    logic                 neg;
    logic                 ovf;

    modport master (output start, op, a, b, input result, busy, done, neg, ovf);
    modport slave  (input start, op, a, b, output result, busy, done, neg, ovf);

endinterface

// File: rtl/arith_unit_shift_add_mul.sv
// shift_add_mul: unsigned shift-add multiplier datapath, one multiplier bit per step.
module shift_add_mul #(
    parameter int WIDTH = 8
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 load_i,
    input  logic                 step_i,
    input  logic [WIDTH-1:0]     a_i,
    input  logic [WIDTH-1:0]     b_i,
    output logic                 last_o,
    output logic [2*WIDTH-1:0]   prod_o
);

    localparam int W2 = 2 * WIDTH;
    localparam int CW = $clog2(WIDTH);

    logic [W2-1:0]    mcand_q;
    logic [WIDTH-1:0] mplier_q;
    logic [W2-1:0]    partial_q;
    logic [CW-1:0]    cnt_q;

    // prod_o already includes the current step, so on the last step it is the final product
    assign prod_o = partial_q + (mplier_q[0] ? mcand_q : '0);
    assign last_o = cnt_q == CW'(WIDTH - 1);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            mcand_q   <= '0;
            mplier_q  <= '0;
            partial_q <= '0;
            cnt_q     <= '0;
        end else if (load_i) begin
            mcand_q   <= {{WIDTH{1'b0}}, a_i};
            mplier_q  <= b_i;
            partial_q <= '0;
            cnt_q     <= '0;
        end else if (step_i) begin
            partial_q <= prod_o;
            mcand_q   <= {mcand_q[W2-2:0], 1'b0};
            mplier_q  <= {1'b0, mplier_q[WIDTH-1:1]};
            cnt_q     <= cnt_q + CW'(1);
        end
    end

endmodule

// File: rtl/arith_unit.sv
// arith_unit: start-edge triggered CLR/ADD/SUB/MUL/ACC unit with registered result and flags.
module arith_unit
    import arith_unit_pkg::*;
#(
    parameter int WIDTH = 8
) (
    input  logic        clk,
    input  logic        rst_n,
    arith_unit_if.slave bus
);

    localparam int W2 = 2 * WIDTH;

    state_t          state_q;
    logic            start_q;
    logic            busy_q;
    logic            done_q;
    logic            neg_q;
    logic            ovf_q;
    logic [W2-1:0]   result_q;
    logic [W2-1:0]   add_d;
    logic [W2-1:0]   sub_d;
    logic [W2:0]     acc_d;
    logic [WIDTH:0]  diff;
    logic [W2-1:0]   prod;
    logic            fire;
    logic            last;

    assign fire  = bus.start && !start_q && state_q == S_IDLE;
    // borrow bit of the widened difference is both the sign and a<b
    assign diff  = {1'b0, bus.a} - {1'b0, bus.b};
    assign add_d = W2'({1'b0, bus.a} + {1'b0, bus.b});
    assign sub_d = {{(WIDTH-1){diff[WIDTH]}}, diff};
    assign acc_d = {1'b0, result_q} + (W2+1)'(bus.a);

    shift_add_mul #(.WIDTH(WIDTH)) u_mul (
        .clk    (clk),
        .rst_n  (rst_n),
        .load_i (fire && bus.op == OP_MUL),
        .step_i (state_q == S_MUL),
        .a_i    (bus.a),
        .b_i    (bus.b),
        .last_o (last),
        .prod_o (prod)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q  <= S_IDLE;
            start_q  <= 1'b1;
            result_q <= '0;
            busy_q   <= 1'b0;
            done_q   <= 1'b0;
            neg_q    <= 1'b0;
            ovf_q    <= 1'b0;
        end else begin
            start_q <= bus.start;
            done_q  <= 1'b0;
            if (fire) begin
                done_q <= bus.op != OP_MUL;
                case (bus.op)
                    OP_CLR: begin
                        result_q <= '0;
                        neg_q    <= 1'b0;
                        ovf_q    <= 1'b0;
                    end
                    OP_ADD: result_q <= add_d;
                    OP_SUB: begin
                        result_q <= sub_d;
                        neg_q    <= diff[WIDTH];
                    end
                    OP_MUL: begin
                        busy_q  <= 1'b1;
                        state_q <= S_MUL;
                    end
                    OP_ACC: begin
                        result_q <= acc_d[W2-1:0];
                        ovf_q    <= ovf_q | acc_d[W2];
                    end
                    default: ;
                endcase
            end else if (state_q == S_MUL && last) begin
                result_q <= prod;
                busy_q   <= 1'b0;
                done_q   <= 1'b1;
                state_q  <= S_IDLE;
            end
        end
    end

    assign bus.result = result_q;
    assign bus.busy   = busy_q;
    assign bus.done   = done_q;
    assign bus.neg    = neg_q;
    assign bus.ovf    = ovf_q;

endmodule

// File: tb/tb_arith_unit.sv
// tb_arith_unit: scoreboard bench for arith_unit at WIDTH=8.
module tb_arith_unit;
    import arith_unit_pkg::*;

    typedef struct packed {
        logic [15:0] res;
        logic        neg;
        logic        ovf;
    } exp_t;

    logic clk = 1'b0;
    logic rst_n = 1'b0;

    arith_unit_if #(.WIDTH(8)) bus();
    arith_unit #(.WIDTH(8)) dut (.clk(clk), .rst_n(rst_n), .bus(bus));

    always #5 clk = ~clk;

    exp_t        sb[$];
    int          n_chk = 0;
    int          n_bad = 0;
    int          n_done = 0;
    int          lat;
    int          bz;
    int          d0;
    logic [15:0] m_res = '0;
    logic        m_neg = 1'b0;
    logic        m_ovf = 1'b0;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    always @(negedge clk) begin : mon
        exp_t e;
        if (rst_n && bus.done) begin
            n_done++;
            if (sb.size() == 0) chk("spurious_done", 1, 0);
            else begin
                e = sb.pop_front();
                chk("result", bus.result, e.res);
                chk("neg", bus.neg, e.neg);
                chk("ovf", bus.ovf, e.ovf);
            end
        end
    end

    task automatic model_reset();
        m_res = '0;
        m_neg = 1'b0;
        m_ovf = 1'b0;
        sb.delete();
    endtask

    task automatic model(input logic [2:0] o, input logic [7:0] x, input logic [7:0] y);
        logic [16:0] s;
        case (o)
            OP_CLR: begin m_res = '0; m_neg = 1'b0; m_ovf = 1'b0; end
            OP_ADD: m_res = 16'(x) + 16'(y);
            OP_SUB: begin m_res = 16'(x) - 16'(y); m_neg = x < y; end
            OP_MUL: m_res = 16'(x) * 16'(y);
            OP_ACC: begin s = 17'(m_res) + 17'(x); m_res = s[15:0]; m_ovf = m_ovf | s[16]; end
            default: ;
        endcase
        sb.push_back('{m_res, m_neg, m_ovf});
    endtask

    // mode 1 holds start high; mode 2 scrambles inputs and pulses start while busy
    task automatic cmd(input logic [2:0] o, input logic [7:0] x, input logic [7:0] y, input int mode = 0);
        logic [15:0] prev;
        prev = m_res;
        @(negedge clk);
        bus.op = o; bus.a = x; bus.b = y; bus.start = 1'b1;
        model(o, x, y);
        lat = 0;
        bz = 0;
        do begin
            @(negedge clk);
            lat++;
            if (bus.busy) begin
                bz++;
                chk("hold_result", bus.result, prev);
            end
            if (mode != 1 && lat == 1) bus.start = 1'b0;
            if (mode == 2 && lat == 2) begin
                bus.start = 1'b1; bus.a = 8'h12; bus.b = 8'h34; bus.op = OP_ADD;
            end
            if (mode == 2 && lat == 3) bus.start = 1'b0;
        end while (!bus.done && lat < 30);
        if (!bus.done) chk("timeout", 1, 0);
        @(negedge clk);
        chk("done_pulse", bus.done, 0);
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog");
        $fatal(1);
    end

    initial begin
        bus.start = 1'b0; bus.op = '0; bus.a = '0; bus.b = '0;
        repeat (3) @(negedge clk);
        chk("rst_result", bus.result, 0);
        chk("rst_busy", bus.busy, 0);
        chk("rst_done", bus.done, 0);
        chk("rst_neg", bus.neg, 0);
        chk("rst_ovf", bus.ovf, 0);
        rst_n = 1'b1;

        cmd(OP_ADD, 8'hFF, 8'hFF);
        chk("add_lat", lat, 1);
        chk("add_busy", bz, 0);
        chk("add_res", bus.result, 16'h01FE);

        cmd(OP_SUB, 8'h10, 8'h20);
        chk("sub1_res", bus.result, 16'hFFF0);
        chk("sub1_neg", bus.neg, 1);
        cmd(OP_SUB, 8'h20, 8'h10);
        chk("sub2_res", bus.result, 16'h0010);
        chk("sub2_neg", bus.neg, 0);

        cmd(OP_MUL, 8'hFF, 8'hFF, 2);
        chk("mul_lat", lat, 9);
        chk("mul_busy", bz, 8);
        chk("mul_res", bus.result, 16'hFE01);
        cmd(OP_MUL, 8'h00, 8'hAB);
        chk("mul0_lat", lat, 9);
        chk("mul0_busy", bz, 8);

        cmd(OP_CLR, 8'h00, 8'h00);
        cmd(OP_MUL, 8'hFF, 8'hFF);
        cmd(OP_ACC, 8'hFF, 8'h00);
        chk("acc1_res", bus.result, 16'hFF00);
        cmd(OP_ACC, 8'hFF, 8'h00);
        chk("acc2_res", bus.result, 16'hFFFF);
        chk("acc2_ovf", bus.ovf, 0);
        cmd(OP_ACC, 8'hFF, 8'h00);
        chk("acc3_res", bus.result, 16'h00FE);
        chk("acc3_ovf", bus.ovf, 1);
        cmd(OP_ADD, 8'h01, 8'h02);
        chk("ovf_sticky", bus.ovf, 1);
        cmd(OP_CLR, 8'h00, 8'h00);
        chk("ovf_clr", bus.ovf, 0);

        cmd(OP_ADD, 8'h05, 8'h06);
        cmd(3'b110, 8'hAA, 8'hBB);
        chk("rsv_res", bus.result, 16'h000B);

        d0 = n_done;
        cmd(OP_ADD, 8'h03, 8'h04, 1);
        repeat (15) @(negedge clk);
        @(posedge clk);
        chk("hold_once", n_done - d0, 1);
        @(negedge clk);
        bus.start = 1'b0;

        @(negedge clk);
        d0 = n_done;
        bus.op = OP_ADD; bus.a = 8'h03; bus.b = 8'h04; bus.start = 1'b1;
        rst_n = 1'b0;
        model_reset();
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        repeat (6) @(negedge clk);
        @(posedge clk);
        chk("rst_hold_nofire", n_done - d0, 0);
        chk("rst_hold_res", bus.result, 0);
        @(negedge clk);
        bus.start = 1'b0;

        cmd(OP_ADD, 8'h05, 8'h06);
        @(negedge clk);
        bus.op = OP_MUL; bus.a = 8'hFF; bus.b = 8'hFF; bus.start = 1'b1;
        @(negedge clk);
        bus.start = 1'b0;
        repeat (3) @(negedge clk);
        chk("mid_busy", bus.busy, 1);
        rst_n = 1'b0;
        #1;
        chk("arst_result", bus.result, 0);
        chk("arst_busy", bus.busy, 0);
        chk("arst_done", bus.done, 0);
        chk("arst_neg", bus.neg, 0);
        chk("arst_ovf", bus.ovf, 0);
        model_reset();
        d0 = n_done;
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        bz = 0;
        repeat (12) begin
            @(negedge clk);
            if (bus.busy) bz++;
        end
        chk("post_busy", bz, 0);
        @(posedge clk);
        chk("post_done", n_done - d0, 0);

        chk("sb_empty", sb.size(), 0);
        $display("test done: total=%0d bad=%0d", n_chk, n_bad);
        $finish;
    end

endmodule
